// File: rtl/qu_uop.sv
// Shared uop and issue-queue entry types, plus the source-tag wakeup compare
// used both for queued entries and for the uop being inserted.
package qu_uop;

    localparam int QU_PHY_RF_DEPTH = 128;
    localparam int QU_PRW          = $clog2(QU_PHY_RF_DEPTH);

    typedef struct packed {
        logic [QU_PRW-1:0] rd;
        logic              rd_valid;
        logic [QU_PRW-1:0] rs1;
        logic              rs1_valid;
        logic [QU_PRW-1:0] rs2;
        logic              rs2_valid;
        logic [3:0]        fu_op;
    } uop_ic_t;

    typedef struct packed {
        logic [31:0] pc;
        uop_ic_t     uop_ic;
    } uop_t;

    typedef struct packed {
        uop_t uop;
        logic valid;
        logic rs1_rdy;
        logic rs2_rdy;
    } iq_entry_t;

    // {rs1 hit, rs2 hit}: a live source operand matches the broadcast tag.
    function automatic logic [1:0] wake_hits(input uop_t u, input logic wv,
                                             input logic [QU_PRW-1:0] tag);
        return {wv && u.uop_ic.rs1_valid && (u.uop_ic.rs1 == tag),
                wv && u.uop_ic.rs2_valid && (u.uop_ic.rs2 == tag)};
    endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority encoder over the per-entry issuable vector.
module iq_select #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          sel_valid,
    output logic [IW-1:0] sel_idx
);

    always_comb begin
        sel_valid = |req;
        sel_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue: index 0 is oldest, occupied slots are
// always 0..count-1, and the oldest entry with both operands ready is offered.
module issue_queue
    import qu_uop::*;
#(
    parameter  int PHY_RF_DEPTH = 128,
    parameter  int IQ_DEPTH     = 8,
    localparam int PRW          = $clog2(PHY_RF_DEPTH),
    localparam int CW           = $clog2(IQ_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    input  uop_t           in_uop,
    output logic           in_ready,
    output logic [PRW-1:0] busy_rd_addr1,
    output logic [PRW-1:0] busy_rd_addr2,
    input  logic           busy_rd_data1,
    input  logic           busy_rd_data2,
    input  logic           wakeup_valid,
    input  logic [PRW-1:0] wakeup_tag,
    output logic           out_valid,
    output uop_t           out_uop,
    input  logic           out_ready,
    output logic [CW-1:0]  count
);

    localparam int IW = $clog2(IQ_DEPTH);

    iq_entry_t             q_reg  [IQ_DEPTH];
    iq_entry_t             q_woke [IQ_DEPTH];
    iq_entry_t             q_next [IQ_DEPTH];
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic [IQ_DEPTH-1:0]   rdy_vec;
    logic                  sel_valid;
    logic [IW-1:0]         sel_idx;
    logic                  insert;
    logic                  issue;
    logic [CW-1:0]         ins_idx;
    logic [1:0]            ins_hit;
    iq_entry_t             new_entry;

    assign busy_rd_addr1 = in_uop.uop_ic.rs1;
    assign busy_rd_addr2 = in_uop.uop_ic.rs2;

    // No bypass when full: a same-cycle issue does not open a slot early.
    assign in_ready = (count_reg != CW'(IQ_DEPTH));
    assign insert   = in_valid && in_ready;
    assign issue    = sel_valid && out_ready;
    assign ins_idx  = count_reg - CW'(issue);
    assign count    = count_reg;

    assign ins_hit = wake_hits(in_uop, wakeup_valid, wakeup_tag);

    always_comb begin
        new_entry         = '0;
        new_entry.uop     = in_uop;
        new_entry.valid   = 1'b1;
        new_entry.rs1_rdy = !in_uop.uop_ic.rs1_valid || !busy_rd_data1 || ins_hit[1];
        new_entry.rs2_rdy = !in_uop.uop_ic.rs2_valid || !busy_rd_data2 || ins_hit[0];
    end

    iq_select #(
        .N(IQ_DEPTH)
    ) u_select (
        .req      (rdy_vec),
        .sel_valid(sel_valid),
        .sel_idx  (sel_idx)
    );

    // Select sees only registered ready bits, so outputs never depend on wakeup.
    assign out_valid = sel_valid;
    assign out_uop   = sel_valid ? q_reg[sel_idx].uop : '0;

    generate
        for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_ent
            logic [1:0] hit;
            iq_entry_t  woke;
            iq_entry_t  shifted;
            iq_entry_t  nxt;

            assign hit = wake_hits(q_reg[gi].uop, wakeup_valid, wakeup_tag);

            always_comb begin
                woke = q_reg[gi];
                if (q_reg[gi].valid) begin
                    woke.rs1_rdy = q_reg[gi].rs1_rdy | hit[1];
                    woke.rs2_rdy = q_reg[gi].rs2_rdy | hit[0];
                end
            end

            assign q_woke[gi]  = woke;
            assign rdy_vec[gi] = q_reg[gi].valid && q_reg[gi].rs1_rdy && q_reg[gi].rs2_rdy;

            if (gi == IQ_DEPTH - 1) begin : g_last
                assign shifted = '0;
            end else begin : g_mid
                assign shifted = q_woke[gi+1];
            end

            // Collapse first, then place the new uop just past the survivors.
            always_comb begin
                nxt = woke;
                if (issue && (IW'(gi) >= sel_idx)) begin
                    nxt = shifted;
                end
                if (insert && (ins_idx == CW'(gi))) begin
                    nxt = new_entry;
                end
            end

            assign q_next[gi] = nxt;
        end
    endgenerate

    assign count_next = count_reg + CW'(insert) - CW'(issue);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                q_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                q_reg[i] <= q_next[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Issue queue bench: directed scenarios plus random traffic, all checked each
// cycle against a queue-based age-order model.
module tb_issue_queue;
    import qu_uop::*;

    localparam int DEPTH = 8;
    localparam int PRW   = QU_PRW;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    uop_t           in_uop;
    logic           in_ready;
    logic [PRW-1:0] busy_rd_addr1;
    logic [PRW-1:0] busy_rd_addr2;
    logic           busy_rd_data1;
    logic           busy_rd_data2;
    logic           wakeup_valid;
    logic [PRW-1:0] wakeup_tag;
    logic           out_valid;
    uop_t           out_uop;
    logic           out_ready;
    logic [3:0]     count;

    always #5 clk = ~clk;

    issue_queue #(
        .PHY_RF_DEPTH(128),
        .IQ_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_uop       (in_uop),
        .in_ready     (in_ready),
        .busy_rd_addr1(busy_rd_addr1),
        .busy_rd_addr2(busy_rd_addr2),
        .busy_rd_data1(busy_rd_data1),
        .busy_rd_data2(busy_rd_data2),
        .wakeup_valid (wakeup_valid),
        .wakeup_tag   (wakeup_tag),
        .out_valid    (out_valid),
        .out_uop      (out_uop),
        .out_ready    (out_ready),
        .count        (count)
    );

    typedef struct {
        uop_t u;
        bit   r1;
        bit   r2;
    } m_ent_t;

    m_ent_t mq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic uop_t mk(input int pc, input int r1, input bit v1,
                                input int r2, input bit v2);
        uop_t u;
        u                  = '0;
        u.pc               = pc;
        u.uop_ic.rs1       = PRW'(r1);
        u.uop_ic.rs1_valid = v1;
        u.uop_ic.rs2       = PRW'(r2);
        u.uop_ic.rs2_valid = v2;
        u.uop_ic.rd        = PRW'(pc);
        u.uop_ic.rd_valid  = 1'b1;
        u.uop_ic.fu_op     = 4'(pc);
        return u;
    endfunction

    // One cycle: drive inputs, compare DUT against model, then advance the model.
    task automatic step(input bit iv, input uop_t u, input bit b1, input bit b2,
                        input bit wv, input int wt, input bit ordy, input bit fl);
        int     sel;
        bit     ins;
        bit     iss;
        m_ent_t e;
        @(negedge clk);
        in_valid      = iv;
        in_uop        = u;
        busy_rd_data1 = b1;
        busy_rd_data2 = b2;
        wakeup_valid  = wv;
        wakeup_tag    = PRW'(wt);
        out_ready     = ordy;
        flush         = fl;
        #1;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
                sel = i;
                break;
            end
        end
        chk("out_valid", 64'(out_valid), 64'(sel >= 0));
        if (sel >= 0) chk("out_uop", 64'(out_uop), 64'(mq[sel].u));
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        chk("busy_addr1", 64'(busy_rd_addr1), 64'(u.uop_ic.rs1));
        chk("busy_addr2", 64'(busy_rd_addr2), 64'(u.uop_ic.rs2));
        ins = iv && (mq.size() != DEPTH);
        iss = (sel >= 0) && ordy;
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (wv && mq[i].u.uop_ic.rs1_valid && int'(mq[i].u.uop_ic.rs1) == wt) mq[i].r1 = 1'b1;
                if (wv && mq[i].u.uop_ic.rs2_valid && int'(mq[i].u.uop_ic.rs2) == wt) mq[i].r2 = 1'b1;
            end
            if (iss) mq.delete(sel);
            if (ins) begin
                e.u  = u;
                e.r1 = !u.uop_ic.rs1_valid || !b1 || (wv && int'(u.uop_ic.rs1) == wt);
                e.r2 = !u.uop_ic.rs2_valid || !b2 || (wv && int'(u.uop_ic.rs2) == wt);
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, ordy, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_uop        = '0;
        busy_rd_data1 = 1'b0;
        busy_rd_data2 = 1'b0;
        wakeup_valid  = 1'b0;
        wakeup_tag    = '0;
        out_ready     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_uop", 64'(out_uop), 64'd0);
        rst = 1'b0;

        // Basic issue
        step(1'b1, mk(1, 5, 1'b1, 6, 1'b1), 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("s1_pre_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_count1", 64'(count), 64'd1);
        idle(1'b1);
        chk("s1_count0", 64'(count), 64'd0);

        // Wakeup is visible the cycle after the broadcast
        step(1'b1, mk(2, 9, 1'b1, 0, 1'b0), 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9, 1'b1, 1'b0);
        chk("s2_same_cycle", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("s2_next_valid", 64'(out_valid), 64'd1);
        chk("s2_next_pc", 64'(out_uop.pc), 64'd2);
        idle(1'b1);
        chk("s2_count0", 64'(count), 64'd0);

        // Age order
        step(1'b1, mk(3, 20, 1'b1, 0, 1'b0), 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, mk(4, 21, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 20, 1'b1, 1'b0);
        chk("s3_b_first", 64'(out_uop.pc), 64'd4);
        step(1'b1, mk(5, 22, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("s3_a_before_c", 64'(out_uop.pc), 64'd3);
        idle(1'b1);
        chk("s3_c_last", 64'(out_uop.pc), 64'd5);
        idle(1'b1);

        // Full
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk(10 + i, 30 + i, 1'b1, 0, 1'b0), 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, mk(99, 1, 1'b0, 2, 1'b0), 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("s4_full_ready", 64'(in_ready), 64'd0);
        chk("s4_full_count", 64'(count), 64'd8);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 33, 1'b0, 1'b0);
        step(1'b1, mk(98, 1, 1'b0, 2, 1'b0), 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("s4_issue_pc", 64'(out_uop.pc), 64'd13);
        chk("s4_no_bypass", 64'(in_ready), 64'd0);
        idle(1'b0);
        chk("s4_ready_after", 64'(in_ready), 64'd1);
        chk("s4_count7", 64'(count), 64'd7);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(1'b0);

        // Insert-time wakeup
        step(1'b1, mk(20, 0, 1'b0, 12, 1'b1), 1'b0, 1'b1, 1'b1, 12, 1'b0, 1'b0);
        idle(1'b1);
        chk("s5_valid", 64'(out_valid), 64'd1);
        chk("s5_pc", 64'(out_uop.pc), 64'd20);
        idle(1'b0);

        // Flush beats a same-cycle insert and issue
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(40 + i, 1, 1'b0, 2, 1'b0), 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("s6_count5", 64'(count), 64'd5);
        step(1'b1, mk(50, 1, 1'b0, 2, 1'b0), 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        idle(1'b0);
        chk("s6_count0", 64'(count), 64'd0);
        chk("s6_out_valid", 64'(out_valid), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 6,
                 mk(int'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                    int'($urandom_range(0, 15)), 1'($urandom)),
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 5, int'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
